digest_hex_sender: RTL and testbench
====================================

// Module: digest_hex_sender
// PURPOSE
//   Sequences the byte-serial UART transmitter so that a complete MD5 digest goes out as text.
//   - Accepts one DIGEST_BITS-wide digest through a valid/ready handshake.
//   - Sends it as lowercase/uppercase ASCII hex, most significant nibble first, with optional CR LF.
//   - Sits between the hash core output and the UART transmitter. Drives its byte/send inputs
//     and watches its sent (idle) flag.
// PARAMETERS
//   DIGEST_BITS  128  digest width; multiple of 4; chars = DIGEST_BITS/4
//   UPPERCASE    0    1: nibbles 10..15 map to 'A'..'F' (0x41..); 0: 'a'..'f' (0x61..)
//   APPEND_CRLF  1    1: append 0x0D, 0x0A after the hex chars; 0: no terminator
// PORTS
//   clock         in   1            system clock, all logic on rising edge
//   reset         in   1            synchronous, active-high
//   digest        in   DIGEST_BITS  digest word, sampled on accept
//   digest_valid  in   1            digest offered
//   digest_ready  out  1            high only in IDLE; accept = valid & ready
//   tx_byte       out  8            character to the UART transmitter
//   tx_send       out  1            one-cycle start strobe to the UART transmitter
//   tx_sent       in   1            UART transmitter idle (1) / busy (0)
//   busy          out  1            high from accept until the last char completes
//   done          out  1            one-cycle pulse when the last char completes
// BEHAVIOUR
//   Reset values
//   - state=IDLE; digest_ready=1; tx_byte=8'h00; tx_send=0; busy=0; done=0; char index=0.
//   - Reset mid-message aborts at once. No further tx_send is issued.
//   - The UART transmitter finishes any char it already started. That char is not re-sent.
//   State machine
//   - IDLE: on accept, latch digest into a shift register, set index=0, go to LOAD. busy=1 next cycle.
//   - LOAD: tx_byte <= ASCII of the current char, go to ISSUE.
//     - Chars 0..DIGEST_BITS/4-1 come from the shift register's top nibble.
//     - The final two chars are 0x0D, 0x0A when APPEND_CRLF=1.
//   - ISSUE: while tx_sent=0, wait with tx_send=0. When tx_sent=1, assert tx_send for exactly
//     this one cycle, then go to WAIT_BUSY.
//   - WAIT_BUSY: wait for tx_sent=0, which confirms the UART transmitter took the char, then go to WAIT_DONE.
//   - WAIT_DONE: wait for tx_sent=1. Then:
//     - If this was the last char: pulse done, clear busy, go to IDLE.
//     - Otherwise: shift the register left by 4, increment index, go to LOAD.
//   Handshake rules
//   - The UART transmitter samples tx_byte bit-by-bit during the frame. tx_byte must therefore be
//     stable from ISSUE until WAIT_DONE exits. It changes only in LOAD.
//   - tx_send is never high in two consecutive cycles.
//   - tx_send is never high unless tx_sent=1 in the same cycle.
//   - digest_valid while busy is ignored: ready=0, nothing is latched, and the in-flight message is unaffected.
//   - done and a new accept cannot coincide. ready rises the cycle after done.
//   Arithmetic
//   - nibble n < 10 -> 8'h30 + n.
//   - nibble n >= 10 -> (UPPERCASE ? 8'h41 : 8'h61) + n - 10.
//   - Index width = clog2(total chars + 1). No wrap: exits on the last index.
//   Latency
//   - Accept to first tx_send = 2 cycles, when tx_sent=1.
//   - Inter-char overhead = 2 cycles (LOAD, ISSUE) after tx_sent returns high.
// TESTING
//   Digest 0x0123456789abcdef_fedcba9876543210, UPPERCASE=0, CRLF=1
//     -> 34 tx_send pulses: bytes "0123456789abcdeffedcba9876543210" then 0D 0A;
//        done pulses once; busy low afterwards.
//   Same digest, UPPERCASE=1 -> chars 10..15 are 0x41..0x46; digits unchanged.
//   Same digest, APPEND_CRLF=0 -> exactly 32 pulses; done follows the 32nd char.
//   tx_sent held 0 for 50 cycles at accept -> no tx_send until tx_sent=1; then normal sequence.
//   digest_valid held high with a second digest during sending -> second digest not accepted
//     until after done; then sent in full.
//   reset asserted after char 5 -> next cycle: tx_send=0, busy=0, ready=1;
//     a new digest afterwards is sent from char 0.
//   Throughout: tx_byte checked stable across each frame, using the real UART transmitter
//     with fsm_clk_freq/baud_rate=8, decoded by a bench UART receiver.

Source files
------------

// File: rtl/digest_hex_sender.sv
// ============================================================================
// Module : digest_hex_sender
// Sends one digest word as ASCII hex (MSB nibble first, optional CR LF)
// through a byte-serial UART transmitter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module digest_hex_sender #(
  parameter int DIGEST_BITS = 128,
  parameter bit UPPERCASE   = 1'b0,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIGEST_BITS-1:0] digest,
  input  logic                   digest_valid,
  output logic                   digest_ready,
  output logic [7:0]             tx_byte,
  output logic                   tx_send,
  input  logic                   tx_sent,
  output logic                   busy,
  output logic                   done
);

  localparam int              NIBBLES    = DIGEST_BITS / 4;
  localparam int              TOTAL      = NIBBLES + (APPEND_CRLF ? 2 : 0);
  localparam int              IDX_W      = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] CR_IDX    = IDX_W'(NIBBLES);
  localparam logic [7:0]      ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DIGEST_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   tx_send_q, tx_send_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic [7:0]             cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return ALPHA_BASE + {4'h0, n} - 8'd10;
  endfunction

  // Indices past the hex nibbles only exist when the terminator is enabled.
  always_comb begin
    if (idx_q < CR_IDX)       cur_char = hex_ascii(shreg_q[DIGEST_BITS-1 -: 4]);
    else if (idx_q == CR_IDX) cur_char = 8'h0D;
    else                      cur_char = 8'h0A;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    tx_byte_d = tx_byte_q;
    tx_send_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (digest_valid && ready_q) begin
          shreg_d = digest;
          idx_d   = '0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_byte_d = cur_char;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (tx_sent) begin
          tx_send_d = 1'b1;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_sent) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // ready stays low on the return to idle so done and accept never coincide.
        if (tx_sent) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            shreg_d = shreg_q << 4;
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      tx_byte_q <= 8'h00;
      tx_send_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      tx_byte_q <= tx_byte_d;
      tx_send_q <= tx_send_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign digest_ready = ready_q;
  assign tx_byte      = tx_byte_q;
  assign tx_send      = tx_send_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_digest_hex_sender.sv
// ============================================================================
// Module : tb_digest_hex_sender
// Three sender lanes (lowercase+CRLF, uppercase+CRLF, lowercase no CRLF),
// each driving a behavioural 8-clocks-per-bit UART transmitter and decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_digest_hex_sender;

  localparam int DW     = 128;
  localparam int BUDGET = 6000;
  localparam logic [DW-1:0] D_SPEC = 128'h0123456789abcdef_fedcba9876543210;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] digest = '0;
  logic [2:0]    digest_valid = '0;
  logic [2:0]    digest_ready, tx_send, tx_sent, busy, done;
  logic [7:0]    tx_byte [3];
  logic          stall = 1'b0;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            ncyc    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [3:0] n, input bit upper);
    string lut;
    lut = upper ? "0123456789ABCDEF" : "0123456789abcdef";
    return lut[n];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam bit UPPER = (g == 1);
    localparam bit CRLF  = (g != 2);
    localparam int NCH   = DW / 4 + (CRLF ? 2 : 0);

    digest_hex_sender #(
      .DIGEST_BITS(DW),
      .UPPERCASE  (UPPER),
      .APPEND_CRLF(CRLF)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .digest      (digest),
      .digest_valid(digest_valid[g]),
      .digest_ready(digest_ready[g]),
      .tx_byte     (tx_byte[g]),
      .tx_send     (tx_send[g]),
      .tx_sent     (tx_sent[g]),
      .busy        (busy[g]),
      .done        (done[g])
    );

    logic [7:0] exp_q [$];
    bit         u_busy = 1'b0;
    bit         u_abort = 1'b0;
    bit         u_stable = 1'b1;
    int         u_cnt = 0;
    logic [7:0] u_ref = '0;
    logic [7:0] u_rx = '0;
    int         pulses = 0;
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         acc_edge = 0;
    bit         first_pend = 1'b0;
    bit         stall_seen = 1'b0;
    bit         prev_send = 1'b0;
    bit         prev_done = 1'b0;

    assign tx_sent[g] = !u_busy && !stall;

    always @(negedge clock) begin
      if (reset) begin
        exp_q.delete();
        if (u_busy) u_abort = 1'b1;
        pulses     = 0;
        first_pend = 1'b0;
        prev_done  = 1'b0;
        prev_send  = 1'b0;
      end else begin
        if (digest_valid[g] && digest_ready[g]) begin
          check($sformatf("u%0d q_empty_at_accept", g), exp_q.size(), 0);
          for (int i = 0; i < DW / 4; i++)
            exp_q.push_back(exp_char(digest[DW-1-4*i -: 4], UPPER));
          if (CRLF) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
          end
          acc_edge   = ncyc + 1;
          first_pend = 1'b1;
          stall_seen = 1'b0;
          pulses     = 0;
        end
        if (first_pend && stall) stall_seen = 1'b1;
        if (prev_done) begin
          check($sformatf("u%0d done_one_cycle", g), done[g], 0);
          check($sformatf("u%0d ready_after_done", g), digest_ready[g], 1);
        end
        prev_done = done[g];
        if (done[g]) begin
          check($sformatf("u%0d pulses", g), pulses, NCH);
          check($sformatf("u%0d drained", g), exp_q.size(), 0);
          check($sformatf("u%0d busy_at_done", g), busy[g], 0);
          done_cnt++;
          pulses = 0;
        end
        if (tx_send[g]) begin
          check($sformatf("u%0d send_gap", g), prev_send, 0);
          check($sformatf("u%0d send_idle", g), tx_sent[g], 1);
          if (exp_q.size() == 0) check($sformatf("u%0d unexpected_send", g), 1, 0);
          else                   check($sformatf("u%0d byte_at_send", g), tx_byte[g], exp_q[0]);
          pulses++;
          if (first_pend) begin
            if (!stall_seen) check($sformatf("u%0d latency", g), ncyc - acc_edge, 2);
            first_pend = 1'b0;
          end
        end
        prev_send = tx_send[g];
      end

      // UART transmitter: start bit, 8 data bits LSB first, stop bit; 8 clocks each.
      if (!u_busy) begin
        if (tx_send[g] && !reset) begin
          u_busy   = 1'b1;
          u_cnt    = 0;
          u_ref    = tx_byte[g];
          u_stable = 1'b1;
          u_rx     = '0;
        end
      end else begin
        u_cnt++;
        if (tx_byte[g] !== u_ref) u_stable = 1'b0;
        if (u_cnt >= 12 && u_cnt <= 68 && (u_cnt % 8) == 4)
          u_rx[(u_cnt-12)/8] = tx_byte[g][(u_cnt-12)/8];
        if (u_cnt == 79) begin
          u_busy = 1'b0;
          if (u_abort) begin
            u_abort = 1'b0;
          end else begin
            rx_cnt++;
            check($sformatf("u%0d byte_stable", g), u_stable, 1);
            if (exp_q.size() == 0) begin
              check($sformatf("u%0d unexpected_rx", g), 1, 0);
            end else begin
              check($sformatf("u%0d rx_byte", g), u_rx, exp_q[0]);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic offer(input logic [DW-1:0] d);
    logic [2:0] pend;
    int n;
    @(posedge clock); #1;
    digest       = d;
    digest_valid = 3'b111;
    n = 0;
    while (digest_valid != 3'b000 && n < BUDGET) begin
      @(negedge clock);
      pend = digest_valid & digest_ready;
      @(posedge clock); #1;
      digest_valid = digest_valid & ~pend;
      n++;
    end
    if (digest_valid != 3'b000) begin
      check("accept_timeout", {29'd0, digest_valid}, 0);
      digest_valid = 3'b000;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(busy == 3'b000 && tx_sent == 3'b111 && digest_valid == 3'b000) && n < BUDGET);
    if (n >= BUDGET) check("idle_timeout", 1, 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [2:0] seen;
    int base;
    int n;

    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d rst_ready", i), digest_ready[i], 1);
      check($sformatf("u%0d rst_busy", i), busy[i], 0);
      check($sformatf("u%0d rst_send", i), tx_send[i], 0);
      check($sformatf("u%0d rst_done", i), done[i], 0);
      check($sformatf("u%0d rst_byte", i), tx_byte[i], 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;

    offer(D_SPEC);
    wait_idle();

    // Transmitter busy at accept: nothing may be sent until it reports idle.
    @(posedge clock); #1;
    stall = 1'b1;
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    seen = '0;
    repeat (50) begin
      @(negedge clock);
      seen = seen | tx_send;
    end
    check("stall_quiet", {29'd0, seen}, 0);
    @(posedge clock); #1;
    stall = 1'b0;
    wait_idle();

    // Second digest held valid while the first is in flight.
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    offer(~D_SPEC);
    wait_idle();

    // Reset while the sixth character is on the line.
    base = g_lane[0].rx_cnt;
    offer(D_SPEC);
    n = 0;
    while (!(g_lane[0].rx_cnt >= base + 5 && g_lane[0].u_busy) && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    if (n >= BUDGET) check("char5_timeout", 1, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d abort_send", i), tx_send[i], 0);
      check($sformatf("u%0d abort_busy", i), busy[i], 0);
      check($sformatf("u%0d abort_ready", i), digest_ready[i], 1);
    end
    wait_idle();

    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    wait_idle();

    check("u0 done_count", g_lane[0].done_cnt, 5);
    check("u1 done_count", g_lane[1].done_cnt, 5);
    check("u2 done_count", g_lane[2].done_cnt, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
